wb8_interconnect: RTL

//  Parametrised 8-bit Wishbone interconnect: 2 masters, NSLAVES slaves. Replaces hand-written

---
 rtl/wb8_interconnect.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/wb8_interconnect.sv
// 8-bit Wishbone interconnect: two masters with round-robin arbitration, table-driven slave
// decode with a fallback slave, and a watchdog that ends hung cycles with ack+err.
module wb8_interconnect #(
   parameter int                    NSLAVES       = 8,
   parameter logic [32*NSLAVES-1:0] SLAVE_BASE    = {NSLAVES{32'h0}},
   parameter logic [32*NSLAVES-1:0] SLAVE_MASK    = {NSLAVES{32'h0}},
   parameter int                    DEFAULT_SLAVE = NSLAVES - 1,
   parameter int                    TIMEOUT       = 255,
   parameter int                    TIMEOUT_BITS  = 8
) (
   input  logic                   I_wb_clk,
   input  logic                   I_reset,
   input  logic                   I_m0_cyc,
   input  logic                   I_m0_stb,
   input  logic                   I_m0_we,
   input  logic [31:0]            I_m0_adr,
   input  logic [7:0]             I_m0_dat,
   output logic [7:0]             O_m0_dat,
   output logic                   O_m0_ack,
   output logic                   O_m0_err,
   output logic                   O_m0_stall,
   input  logic                   I_m1_cyc,
   input  logic                   I_m1_stb,
   input  logic                   I_m1_we,
   input  logic [31:0]            I_m1_adr,
   input  logic [7:0]             I_m1_dat,
   output logic [7:0]             O_m1_dat,
   output logic                   O_m1_ack,
   output logic                   O_m1_err,
   output logic                   O_m1_stall,
   output logic [NSLAVES-1:0]     O_s_stb,
   output logic                   O_s_we,
   output logic [31:0]            O_s_adr,
   output logic [7:0]             O_s_dat,
   input  logic [8*NSLAVES-1:0]   I_s_dat,
   input  logic [NSLAVES-1:0]     I_s_ack,
   input  logic [NSLAVES-1:0]     I_s_stall,
   output logic                   O_err_flag,
   output logic [31:0]            O_err_adr,
   input  logic                   I_err_clear
);
   localparam int SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
   localparam logic [TIMEOUT_BITS-1:0] TIMEOUT_VAL = TIMEOUT_BITS'(TIMEOUT);

   typedef enum logic [1:0] {GNT_NONE, GNT_M0, GNT_M1} grant_t;

   grant_t                  grant_reg;
   logic                    last_m1_reg;
   logic [TIMEOUT_BITS-1:0] wd_reg;
   logic                    err_flag_reg;
   logic [31:0]             err_adr_reg;

   logic        own_stb, own_we;
   logic [31:0] own_adr;
   logic [7:0]  own_wdat;

   always_comb begin
      own_stb  = 1'b0;
      own_we   = 1'b0;
      own_adr  = 32'h0;
      own_wdat = 8'h0;
      case (grant_reg)
         GNT_M0: begin
            own_stb  = I_m0_stb;
            own_we   = I_m0_we;
            own_adr  = I_m0_adr;
            own_wdat = I_m0_dat;
         end
         GNT_M1: begin
            own_stb  = I_m1_stb;
            own_we   = I_m1_we;
            own_adr  = I_m1_adr;
            own_wdat = I_m1_dat;
         end
         default: ;
      endcase
   end

   logic [NSLAVES-1:0] match;
   logic [SEL_W-1:0]   sel;

   genvar gi;
   generate
      for (gi = 0; gi < NSLAVES; gi++) begin : g_match
         assign match[gi] = ((own_adr ^ SLAVE_BASE[32*gi +: 32]) & SLAVE_MASK[32*gi +: 32]) == 32'h0;
      end
   endgenerate

   // Scan downwards so the lowest matching index is the one that sticks.
   always_comb begin
      sel = SEL_W'(DEFAULT_SLAVE);
      for (int i = NSLAVES - 1; i >= 0; i--) begin
         if (match[i]) sel = SEL_W'(i);
      end
   end

   logic       slave_ack, slave_stall, timeout_hit, own_ack;
   logic [7:0] slave_rdat, own_rdat;

   assign slave_ack   = I_s_ack[sel];
   assign slave_stall = I_s_stall[sel];
   assign slave_rdat  = I_s_dat[{sel, 3'b000} +: 8];
   // A real slave ack in the expiry cycle takes precedence over the watchdog.
   assign timeout_hit = (TIMEOUT != 0) && own_stb && !slave_ack && (wd_reg == TIMEOUT_VAL);
   assign own_ack     = slave_ack || timeout_hit;
   assign own_rdat    = timeout_hit ? 8'hFF : slave_rdat;

   generate
      for (gi = 0; gi < NSLAVES; gi++) begin : g_stb
         assign O_s_stb[gi] = own_stb && !timeout_hit && (sel == SEL_W'(gi));
      end
   endgenerate

   assign O_s_we  = own_we;
   assign O_s_adr = own_adr;
   assign O_s_dat = own_wdat;

   assign O_m0_dat   = (grant_reg == GNT_M0) ? own_rdat : 8'h0;
   assign O_m0_ack   = (grant_reg == GNT_M0) && own_ack;
   assign O_m0_err   = (grant_reg == GNT_M0) && timeout_hit;
   assign O_m0_stall = (grant_reg == GNT_M0) ? slave_stall : I_m0_cyc;
   assign O_m1_dat   = (grant_reg == GNT_M1) ? own_rdat : 8'h0;
   assign O_m1_ack   = (grant_reg == GNT_M1) && own_ack;
   assign O_m1_err   = (grant_reg == GNT_M1) && timeout_hit;
   assign O_m1_stall = (grant_reg == GNT_M1) ? slave_stall : I_m1_cyc;

   assign O_err_flag = err_flag_reg;
   assign O_err_adr  = err_adr_reg;

   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         grant_reg    <= GNT_NONE;
         last_m1_reg  <= 1'b1;
         wd_reg       <= '0;
         err_flag_reg <= 1'b0;
         err_adr_reg  <= 32'h0;
      end else begin
         case (grant_reg)
            GNT_NONE: begin
               if (I_m0_cyc && (!I_m1_cyc || last_m1_reg)) begin
                  grant_reg   <= GNT_M0;
                  last_m1_reg <= 1'b0;
               end else if (I_m1_cyc) begin
                  grant_reg   <= GNT_M1;
                  last_m1_reg <= 1'b1;
               end
            end
            GNT_M0: begin
               if (!I_m0_cyc) begin
                  if (I_m1_cyc) begin
                     grant_reg   <= GNT_M1;
                     last_m1_reg <= 1'b1;
                  end else begin
                     grant_reg <= GNT_NONE;
                  end
               end
            end
            GNT_M1: begin
               if (!I_m1_cyc) begin
                  if (I_m0_cyc) begin
                     grant_reg   <= GNT_M0;
                     last_m1_reg <= 1'b0;
                  end else begin
                     grant_reg <= GNT_NONE;
                  end
               end
            end
            default: grant_reg <= GNT_NONE;
         endcase

         if ((TIMEOUT == 0) || !own_stb || slave_ack || timeout_hit)
            wd_reg <= '0;
         else
            wd_reg <= wd_reg + 1'b1;

         // A new timeout overrides a simultaneous clear request.
         if (timeout_hit) begin
            err_flag_reg <= 1'b1;
            err_adr_reg  <= own_adr;
         end else if (I_err_clear) begin
            err_flag_reg <= 1'b0;
         end
      end
   end
endmodule
